// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions: constants, field extractors and the
// sequential multiplier state encoding.
package fp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, CALC, PACK, DONE} state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_op,
  output logic        o_is_zero,
  output logic        o_is_inf,
  output logic        o_is_nan,
  output logic        o_is_denorm
);

  logic [7:0]  w_exp;
  logic [22:0] w_mant;

  assign w_exp       = f_exp(i_op);
  assign w_mant      = f_mant(i_op);
  assign o_is_zero   = (w_exp == 8'h00) && (w_mant == '0);
  assign o_is_denorm = (w_exp == 8'h00) && (w_mant != '0);
  assign o_is_inf    = (w_exp == EXP_MAX) && (w_mant == '0);
  assign o_is_nan    = (w_exp == EXP_MAX) && (w_mant != '0);

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier, radix-2 shift-add datapath.
// Optional macro FP_MUL_SEQ_RNE_EN: round-to-nearest-even in PACK instead of
// truncation.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  if (XLEN != 32) begin : g_xlen_check
    $fatal(1, "fp_mul_seq: only XLEN=32 is supported");
  end

  state_t      r_state;
  logic        r_in_ready, r_out_valid, r_ovf, r_unf, r_exc;
  logic [31:0] r_result;
  logic        r_sign;
  logic [7:0]  r_exp_a, r_exp_b;
  logic [23:0] r_mcand, r_acc_hi, r_mplr;
  logic [4:0]  r_cnt;
  logic        r_spec, r_spec_exc;
  logic [31:0] r_spec_res;

  logic w_a_zero, w_a_inf, w_a_nan, w_a_den;
  logic w_b_zero, w_b_inf, w_b_nan, w_b_den;

  fp_classify u_cls_a (
    .i_op(A), .o_is_zero(w_a_zero), .o_is_inf(w_a_inf),
    .o_is_nan(w_a_nan), .o_is_denorm(w_a_den)
  );
  fp_classify u_cls_b (
    .i_op(B), .o_is_zero(w_b_zero), .o_is_inf(w_b_inf),
    .o_is_nan(w_b_nan), .o_is_denorm(w_b_den)
  );

  logic        w_sign_in, w_spec, w_spec_exc;
  logic [31:0] w_spec_res;

  // Special-operand decision made on the operands being accepted
  always_comb begin
    w_sign_in  = f_sign(A) ^ f_sign(B);
    w_spec     = w_a_nan | w_b_nan | w_a_inf | w_b_inf |
                 w_a_zero | w_a_den | w_b_zero | w_b_den;
    w_spec_exc = 1'b0;
    w_spec_res = {w_sign_in, 31'h0};
    if (w_a_nan || w_b_nan || (w_a_inf && (w_b_zero || w_b_den)) ||
        (w_b_inf && (w_a_zero || w_a_den))) begin
      w_spec_res = QNAN;
      w_spec_exc = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res = {w_sign_in, EXP_MAX, 23'h0};
      w_spec_exc = 1'b1;
    end
  end

  logic [24:0] w_sum;
  assign w_sum = {1'b0, r_acc_hi} + (r_mplr[0] ? {1'b0, r_mcand} : 25'd0);

  logic              w_norm;
  logic [22:0]       w_mant, w_mant_f;
  logic signed [9:0] w_exp, w_exp_f;
  logic              w_ovf, w_unf;

  // Product {r_acc_hi, r_mplr} normalisation, exponent and range check
  always_comb begin
    w_norm = r_acc_hi[23];
    w_mant = w_norm ? r_acc_hi[22:0] : {r_acc_hi[21:0], r_mplr[23]};
    w_exp  = 10'({2'b00, r_exp_a}) + 10'({2'b00, r_exp_b}) - 10'(EXP_BIAS)
             + 10'({9'd0, w_norm});
`ifdef FP_MUL_SEQ_RNE_EN
    begin
      logic        w_g, w_r, w_s, w_rup;
      logic [23:0] w_mant_r;
      w_g      = w_norm ? r_mplr[23] : r_mplr[22];
      w_r      = w_norm ? r_mplr[22] : r_mplr[21];
      w_s      = w_norm ? (|r_mplr[21:0]) : (|r_mplr[20:0]);
      w_rup    = w_g & (w_r | w_s | w_mant[0]);
      w_mant_r = {1'b0, w_mant} + {23'd0, w_rup};
      // carry out of the fraction means 1.11..1 rounded up to 2.0
      w_mant_f = w_mant_r[22:0];
      w_exp_f  = w_exp + 10'({9'd0, w_mant_r[23]});
    end
`else
    w_mant_f = w_mant;
    w_exp_f  = w_exp;
`endif
    w_ovf = (w_exp_f >= 10'sd255);
    w_unf = (w_exp_f <= 10'sd0);
  end

  // Control FSM, shift-add datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_exc       <= 1'b0;
      r_sign      <= 1'b0;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_mcand     <= '0;
      r_acc_hi    <= '0;
      r_mplr      <= '0;
      r_cnt       <= '0;
      r_spec      <= 1'b0;
      r_spec_exc  <= 1'b0;
      r_spec_res  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= w_sign_in;
            r_exp_a    <= f_exp(A);
            r_exp_b    <= f_exp(B);
            r_mcand    <= {1'b1, f_mant(A)};
            r_mplr     <= {1'b1, f_mant(B)};
            r_acc_hi   <= '0;
            r_cnt      <= '0;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_spec_exc <= w_spec_exc;
            r_in_ready <= 1'b0;
            r_state    <= w_spec ? PACK : CALC;
          end
        end
        CALC: begin
          r_acc_hi <= w_sum[24:1];
          r_mplr   <= {w_sum[0], r_mplr[23:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) r_state <= PACK;
        end
        PACK: begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
          r_exc <= 1'b0;
          if (r_spec) begin
            r_result <= r_spec_res;
            r_exc    <= r_spec_exc;
          end else if (w_ovf) begin
            r_result <= {r_sign, EXP_MAX, 23'h0};
            r_ovf    <= 1'b1;
          end else if (w_unf) begin
            r_result <= {r_sign, 31'h0};
            r_unf    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_f[7:0], w_mant_f};
          end
          r_state <= DONE;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_exc       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;

endmodule
